hs_pack: RTL and testbench

HS_PACK -- requirements
Module: hs_pack

---
 rtl/hs_pack_pkg.sv | 17 +
 rtl/hs_pack_register.sv | 25 ++
 rtl/hs_pack.sv | 98 +++++++++
 tb/tb_hs_pack.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/hs_pack_pkg.sv
// hs_pack_pkg
//   Shared helpers for the hs_pack handshake packer.
//   Provides clog2, used to size the lane counter and the output count.
//   No ports; imported with "import hs_pack_pkg::*;".
package hs_pack_pkg;

  // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/hs_pack_register.sv
// hs_pack_register
//   Generic enabled register with synchronous active-high clear.
//   Used for the packed data, lane count and valid flag of hs_pack.
// Ports
//   clock  : rising-edge clock
//   clear  : synchronous clear, highest priority, forces q to 0
//   enable : load d into q
//   d      : next value
//   q      : registered value
module hs_pack_register #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock) begin
    if (clear)       q <= '0;
    else if (enable) q <= d;
  end

endmodule

// File: rtl/hs_pack.sv
// hs_pack
//   Packs PACK_COUNT input words of WORD_WIDTH bits into one output word
//   using valid/ready handshakes on both sides. input_last closes a pack
//   early; unused upper lanes are then zero. Lane 0 is least significant.
// Ports
//   clock         : rising-edge clock
//   clear         : synchronous active-high reset
//   input_valid   : upstream word present
//   input_ready   : this stage accepts a word this cycle
//   input_data    : upstream word
//   input_last    : closes the current pack with this word
//   output_valid  : packed word present
//   output_ready  : downstream accepts
//   output_data   : packed word
//   output_count  : number of valid lanes in output_data
module hs_pack
  import hs_pack_pkg::*;
#(
  parameter int WORD_WIDTH = 10,
  parameter int PACK_COUNT = 4,
  localparam int COUNT_BITS = clog2(PACK_COUNT + 1)
) (
  input  logic                             clock,
  input  logic                             clear,
  input  logic                             input_valid,
  output logic                             input_ready,
  input  logic [WORD_WIDTH-1:0]            input_data,
  input  logic                             input_last,
  output logic                             output_valid,
  input  logic                             output_ready,
  output logic [WORD_WIDTH*PACK_COUNT-1:0] output_data,
  output logic [COUNT_BITS-1:0]            output_count
);

  localparam int LANE_BITS  = clog2(PACK_COUNT);
  localparam int PACK_WIDTH = WORD_WIDTH * PACK_COUNT;
  localparam logic [LANE_BITS-1:0] LAST_LANE = LANE_BITS'(PACK_COUNT - 1);

  logic [PACK_WIDTH-1:0] accumulator;
  logic [LANE_BITS-1:0]  lane;
  logic [PACK_WIDTH-1:0] pack_next;
  logic                  insert;
  logic                  remove;
  logic                  close;

  // The output slot is free when empty or being drained this cycle, so the
  // upstream may push regardless of what it is offering.
  assign input_ready = !output_valid || output_ready;
  assign insert      = input_valid && input_ready;
  assign remove      = output_valid && output_ready;
  assign close       = insert && ((lane == LAST_LANE) || input_last);

  // Accumulator lanes at and above the counter are always zero, so dropping
  // the new word into lane k yields the zero-padded pack directly.
  always_comb begin
    pack_next = accumulator;
    for (int i = 0; i < PACK_COUNT; i++) begin
      if (lane == LANE_BITS'(i)) pack_next[i*WORD_WIDTH +: WORD_WIDTH] = input_data;
    end
  end

  always_ff @(posedge clock) begin
    if (clear || close) begin
      accumulator <= '0;
      lane        <= '0;
    end else if (insert) begin
      accumulator <= pack_next;
      lane        <= lane + LANE_BITS'(1);
    end
  end

  hs_pack_register #(.WIDTH(PACK_WIDTH)) data_reg (
    .clock  (clock),
    .clear  (clear),
    .enable (close),
    .d      (pack_next),
    .q      (output_data)
  );

  hs_pack_register #(.WIDTH(COUNT_BITS)) count_reg (
    .clock  (clock),
    .clear  (clear),
    .enable (close),
    .d      (COUNT_BITS'(lane) + COUNT_BITS'(1)),
    .q      (output_count)
  );

  // A close refills the slot even while it drains, giving back-to-back packs;
  // a drain without a close empties it.
  hs_pack_register #(.WIDTH(1)) valid_reg (
    .clock  (clock),
    .clear  (clear),
    .enable (close || remove),
    .d      (close),
    .q      (output_valid)
  );

endmodule

// File: tb/tb_hs_pack.sv
// tb_hs_pack
//   Directed self-checking bench for hs_pack with WORD_WIDTH=10,
//   PACK_COUNT=4. Inputs change 1 ns after each rising edge; outputs are
//   checked there as well.
module tb_hs_pack;

  localparam int W = 10;
  localparam int P = 4;

  logic          clock;
  logic          clear;
  logic          input_valid;
  logic          input_ready;
  logic [W-1:0]  input_data;
  logic          input_last;
  logic          output_valid;
  logic          output_ready;
  logic [W*P-1:0] output_data;
  logic [2:0]    output_count;

  int pass_count;
  int check_count;

  hs_pack #(.WORD_WIDTH(W), .PACK_COUNT(P)) dut (
    .clock        (clock),
    .clear        (clear),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .input_data   (input_data),
    .input_last   (input_last),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .output_data  (output_data),
    .output_count (output_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [W-1:0] data,
                               input logic last, input logic oready);
    input_valid  = valid;
    input_data   = data;
    input_last   = last;
    output_ready = oready;
  endtask

  task automatic checkValue(input string tag, input logic [63:0] observed,
                            input logic [63:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic checkOutput(input string tag, input logic valid,
                             input logic [2:0] count, input logic [W*P-1:0] data);
    checkValue({tag, ".valid"}, 64'(output_valid), 64'(valid));
    checkValue({tag, ".count"}, 64'(output_count), 64'(count));
    checkValue({tag, ".data"},  64'(output_data),  64'(data));
  endtask

  initial begin
    pass_count  = 0;
    check_count = 0;
    clear = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("reset", 1'b0, 3'd0, '0);
    clear = 1'b0;
    #1;
    checkValue("reset.in_ready", 64'(input_ready), 64'd1);

    // Full pack of four words
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, W'(i), 1'b0, 1'b1);
      tick();
      if (i < 4) checkValue("full.pending", 64'(output_valid), 64'd0);
    end
    checkOutput("full", 1'b1, 3'd4, {10'd4, 10'd3, 10'd2, 10'd1});
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    tick();
    checkValue("full.drained", 64'(output_valid), 64'd0);

    // Early close on input_last
    applyStimulus(1'b1, 10'h0AA, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 10'h055, 1'b1, 1'b1);
    tick();
    checkOutput("early", 1'b1, 3'd2, {20'd0, 10'h055, 10'h0AA});
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    tick();
    checkValue("early.drained", 64'(output_valid), 64'd0);

    // Backpressure: blocked word 9 with last must be ignored until release
    for (int i = 5; i <= 8; i++) begin
      applyStimulus(1'b1, W'(i), 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 10'd9, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkValue("bp.in_ready", 64'(input_ready), 64'd0);
      checkOutput("bp.hold", 1'b1, 3'd4, {10'd8, 10'd7, 10'd6, 10'd5});
      tick();
    end
    applyStimulus(1'b1, 10'd9, 1'b0, 1'b1);
    #1;
    checkValue("bp.release_ready", 64'(input_ready), 64'd1);
    tick();
    checkValue("bp.released", 64'(output_valid), 64'd0);
    applyStimulus(1'b1, 10'd10, 1'b1, 1'b1);
    tick();
    checkOutput("bp.next", 1'b1, 3'd2, {20'd0, 10'd10, 10'd9});

    // Streaming twelve words with output_ready held high
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, W'(12'h100 + i), 1'b0, 1'b1);
      #1;
      checkValue("stream.in_ready", 64'(input_ready), 64'd1);
      tick();
      if (i % 4 == 3) begin
        checkOutput("stream.pack", 1'b1, 3'd4,
                    {W'(12'h100 + i), W'(12'h100 + i - 1),
                     W'(12'h100 + i - 2), W'(12'h100 + i - 3)});
      end
    end

    // Single-word packs drained and refilled every cycle with no bubble
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, W'(10'h200 + i), 1'b1, 1'b1);
      tick();
      checkOutput("b2b", 1'b1, 3'd1, {30'd0, W'(10'h200 + i)});
    end

    // Clear mid-pack, with an insert offered in the same cycle
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 10'h3FF, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 10'h3FE, 1'b0, 1'b1);
    tick();
    clear = 1'b1;
    applyStimulus(1'b1, 10'h111, 1'b1, 1'b1);
    tick();
    clear = 1'b0;
    checkOutput("clear", 1'b0, 3'd0, '0);
    checkValue("clear.in_ready", 64'(input_ready), 64'd1);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, W'(10'h020 + i), 1'b0, 1'b1);
      tick();
      if (i < 4) checkValue("clear.pending", 64'(output_valid), 64'd0);
    end
    checkOutput("clear.pack", 1'b1, 3'd4, {10'h024, 10'h023, 10'h022, 10'h021});

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
